// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared definitions for the arbitrating multiplexer and its arbiter.
//   ARB_FIXED - lowest asserted index wins every cycle
//   ARB_RR    - rotating priority starting at the stored pointer
package rr_arb_mux_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational request arbiter with grant-to-index encoder.
// Ports:
//   req       - per-channel request (valid) vector
//   ptr       - round-robin start index (ignored in fixed-priority mode)
//   grant     - one-hot grant, zero when no request
//   grant_idx - binary index of the granted channel (0 when none)
//   grant_any - at least one request is asserted
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned MODE   = ARB_RR,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_any
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (MODE == ARB_RR) begin
                // ptr < NUM_IN, so one conditional subtract is a full modulo
                idx = 32'(ptr) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
            end else begin
                idx = k;
            end
            if (!found && req[idx[SEL_W-1:0]]) begin
                grant[idx[SEL_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (grant[k]) begin
                grant_idx = SEL_W'(k);
            end
        end
    end

    assign grant_any = |req;

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating multiplexer with a single registered output stage.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   flush      - drop the buffered word and accept nothing this cycle
//   in_data    - flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready, one-hot or zero
//   out_data   - registered data word
//   out_src    - index of the channel that produced out_data
//   out_valid  - output register holds a word
//   out_ready  - consumer accepts this cycle
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned MODE   = ARB_RR,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic              load;
    logic              xfer;

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .MODE   (MODE)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        // Register can take a word when empty or draining; flush blocks it outright
        load     = !flush && (!out_valid_q || out_ready);
        xfer     = load && grant_any;
        in_ready = {NUM_IN{load}} & grant;

        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_data_d  = in_data[32'(grant_idx)*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Explicit wrap: NUM_IN need not be a power of two
        if (MODE == ARB_RR && xfer) begin
            if (grant_idx == SEL_W'(NUM_IN - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule
